// File: rtl/pio_addr_gen_if.sv
// Memory-mapped slave bus of the PIO address generator: register select,
// write strobe and zero-wait-state read data.
interface pio_addr_gen_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_addr_gen.sv
// Programmable address generator: a bus-writable DATA register that steps by
// STEP on each adv strobe, saturating at or wrapping modulo LIMIT+1.
module pio_addr_gen #(
    parameter int              WIDTH       = 15,
    parameter logic [31:0]     RESET_VALUE = 32'd0,
    parameter logic [WIDTH-1:0] LIMIT_RESET = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_addr_gen_if.slave        bus,
    input  logic                 adv,
    output logic [WIDTH-1:0]     out_port,
    output logic                 update,
    output logic                 irq
);

    localparam logic [WIDTH-1:0] DATA_RST = RESET_VALUE[WIDTH-1:0];

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_LIMIT  = 3'd1;
    localparam logic [2:0] A_STEP   = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLEAR  = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    logic [WIDTH-1:0] data_q,   data_d;
    logic [WIDTH-1:0] limit_q,  limit_d;
    logic [WIDTH-1:0] step_q,   step_d;
    logic             auto_q,   auto_d;
    logic             wrap_q,   wrap_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q,   done_d;
    logic             update_q, update_d;

    logic             wr;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH:0]   adv_res;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, bus.writedata[31:WIDTH]};

    // Result of one advance as {done_set, next_data}, using the current
    // (pre-write) LIMIT/STEP/WRAP values.
    function automatic logic [WIDTH:0] advance(
        input logic [WIDTH-1:0] data,
        input logic [WIDTH-1:0] limit,
        input logic [WIDTH-1:0] step,
        input logic             wrap
    );
        logic [WIDTH:0] sum;
        logic [WIDTH:0] wrapped;
        sum     = {1'b0, data} + {1'b0, step};
        wrapped = sum - {1'b0, limit} - {{WIDTH{1'b0}}, 1'b1};
        if (step == '0)
            advance = {(data > limit), data};
        else if (sum <= {1'b0, limit})
            advance = {1'b0, sum[WIDTH-1:0]};
        else if (wrap)
            advance = {1'b1, wrapped[WIDTH-1:0]};
        else
            advance = {1'b1, limit};
    endfunction

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wdat    = bus.writedata[WIDTH-1:0];
    assign adv_res = advance(data_q, limit_q, step_q, wrap_q);

    always_comb begin
        data_d   = data_q;
        limit_d  = limit_q;
        step_d   = step_q;
        auto_d   = auto_q;
        wrap_d   = wrap_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;

        if (wr && bus.address == A_STATUS && bus.writedata[0])
            done_d = 1'b0;

        if (adv && auto_q) begin
            data_d = adv_res[WIDTH-1:0];
            if (adv_res[WIDTH])
                done_d = 1'b1;
        end

        // Bus writes to DATA/SET/CLEAR override a coincident advance entirely.
        if (wr) begin
            unique case (bus.address)
                A_DATA: begin
                    data_d = wdat;
                    done_d = done_q & ~(bus.writedata[0] & 1'b0);
                end
                A_SET:   data_d = data_q | wdat;
                A_CLEAR: data_d = data_q & ~wdat;
                A_LIMIT: limit_d = wdat;
                A_STEP:  step_d  = wdat;
                A_CTRL: begin
                    auto_d   = bus.writedata[0];
                    wrap_d   = bus.writedata[1];
                    irq_en_d = bus.writedata[2];
                end
                default: ;
            endcase
            if (bus.address == A_DATA || bus.address == A_SET || bus.address == A_CLEAR)
                done_d = done_q;
        end

        update_d = (data_d != data_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= DATA_RST;
            limit_q  <= LIMIT_RESET;
            step_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
            auto_q   <= 1'b0;
            wrap_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            update_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            limit_q  <= limit_d;
            step_q   <= step_d;
            auto_q   <= auto_d;
            wrap_q   <= wrap_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            update_q <= update_d;
        end
    end

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            A_DATA:   bus.readdata = {{(32-WIDTH){1'b0}}, data_q};
            A_LIMIT:  bus.readdata = {{(32-WIDTH){1'b0}}, limit_q};
            A_STEP:   bus.readdata = {{(32-WIDTH){1'b0}}, step_q};
            A_CTRL:   bus.readdata = {29'b0, irq_en_q, wrap_q, auto_q};
            A_STATUS: bus.readdata = {31'b0, done_q};
            default:  bus.readdata = '0;
        endcase
    end

    assign out_port = data_q;
    assign update   = update_q;
    assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_pio_addr_gen.sv
// Directed bench for pio_addr_gen with the default 15-bit configuration.
module tb_pio_addr_gen;

    logic        clk;
    logic        reset_n;
    logic        adv;
    logic [14:0] out_port;
    logic        update;
    logic        irq;
    int          vectors;
    int          miscompares;

    pio_addr_gen_if bus ();

    pio_addr_gen dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .adv      (adv),
        .out_port (out_port),
        .update   (update),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; outputs settle 1 time unit after the edge.
    task automatic cyc(input logic a, input logic w, input logic [2:0] ad, input logic [31:0] d);
        adv            = a;
        bus.chipselect = w;
        bus.write_n    = ~w;
        bus.address    = ad;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        adv            = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] ad, input logic [31:0] exp);
        bus.address = ad;
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        adv            = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        #12;
        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_upd", 32'(update), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        #6 reset_n = 1'b1;
        @(posedge clk); #1;
        rd("rd_data",   3'd0, 32'h0);
        rd("rd_limit",  3'd1, 32'h7FFF);
        rd("rd_step",   3'd2, 32'h1);
        rd("rd_ctrl",   3'd3, 32'h0);
        rd("rd_status", 3'd6, 32'h0);
        rd("rd_addr4",  3'd4, 32'h0);
        @(posedge clk); #1;

        // Bus DATA / SET / CLEAR
        cyc(0, 1, 3'd0, 32'hFFFF_00F0);
        chk("wr_data", 32'(out_port), 32'h00F0);
        chk("wr_data_upd", 32'(update), 32'h1);
        cyc(0, 0, 3'd0, 32'h0);
        chk("idle_upd", 32'(update), 32'h0);
        cyc(0, 1, 3'd4, 32'h000F);
        chk("set", 32'(out_port), 32'h00FF);
        chk("set_upd", 32'(update), 32'h1);
        cyc(0, 1, 3'd5, 32'h0030);
        chk("clear", 32'(out_port), 32'h00CF);
        chk("clear_upd", 32'(update), 32'h1);
        cyc(0, 1, 3'd0, 32'h00CF);
        chk("same_wr_upd", 32'(update), 32'h0);

        // Wrapping advance
        cyc(0, 1, 3'd1, 32'd10);
        cyc(0, 1, 3'd2, 32'd3);
        cyc(0, 1, 3'd3, 32'b011);
        cyc(0, 1, 3'd0, 32'd0);
        cyc(1, 0, 3'd0, 32'd0); chk("wrap_a1", 32'(out_port), 32'd3);
        chk("wrap_a1_upd", 32'(update), 32'h1);
        cyc(1, 0, 3'd0, 32'd0); chk("wrap_a2", 32'(out_port), 32'd6);
        cyc(1, 0, 3'd0, 32'd0); chk("wrap_a3", 32'(out_port), 32'd9);
        rd("wrap_done0", 3'd6, 32'h0);
        cyc(1, 0, 3'd0, 32'd0); chk("wrap_a4", 32'(out_port), 32'd1);
        rd("wrap_done1", 3'd6, 32'h1);
        chk("wrap_irq_off", 32'(irq), 32'h0);

        // Saturating advance with interrupt
        cyc(0, 1, 3'd6, 32'h1);
        rd("status_clr", 3'd6, 32'h0);
        cyc(0, 1, 3'd3, 32'b101);
        cyc(0, 1, 3'd0, 32'd0);
        cyc(1, 0, 3'd0, 32'd0); chk("sat_a1", 32'(out_port), 32'd3);
        cyc(1, 0, 3'd0, 32'd0); chk("sat_a2", 32'(out_port), 32'd6);
        cyc(1, 0, 3'd0, 32'd0); chk("sat_a3", 32'(out_port), 32'd9);
        chk("sat_irq0", 32'(irq), 32'h0);
        cyc(1, 0, 3'd0, 32'd0); chk("sat_a4", 32'(out_port), 32'd10);
        chk("sat_irq1", 32'(irq), 32'h1);
        cyc(1, 0, 3'd0, 32'd0); chk("sat_a5", 32'(out_port), 32'd10);
        chk("sat_a5_upd", 32'(update), 32'h0);
        rd("sat_done", 3'd6, 32'h1);
        cyc(0, 1, 3'd6, 32'h1);
        chk("irq_clr", 32'(irq), 32'h0);

        // Write-vs-advance priority and set-beats-clear
        cyc(1, 1, 3'd0, 32'h5);
        chk("prio_data", 32'(out_port), 32'h5);
        rd("prio_done", 3'd6, 32'h0);
        cyc(0, 1, 3'd0, 32'd9);
        cyc(1, 1, 3'd6, 32'h1);
        chk("setwins_out", 32'(out_port), 32'd10);
        rd("setwins_done", 3'd6, 32'h1);
        chk("setwins_irq", 32'(irq), 32'h1);

        // AUTO=0 ignores adv
        cyc(0, 1, 3'd3, 32'b000);
        chk("ctrl_irq_off", 32'(irq), 32'h0);
        cyc(0, 1, 3'd6, 32'h1);
        cyc(1, 0, 3'd0, 32'd0);
        chk("noauto_out", 32'(out_port), 32'd10);
        chk("noauto_upd", 32'(update), 32'h0);
        rd("noauto_done", 3'd6, 32'h0);

        // STEP written alongside an advance takes effect one cycle later
        cyc(0, 1, 3'd3, 32'b001);
        cyc(0, 1, 3'd0, 32'd0);
        cyc(1, 1, 3'd2, 32'd5);
        chk("oldstep", 32'(out_port), 32'd3);
        cyc(1, 0, 3'd0, 32'd0);
        chk("newstep", 32'(out_port), 32'd8);

        // STEP=0 and LIMIT below DATA
        cyc(0, 1, 3'd2, 32'd0);
        cyc(1, 0, 3'd0, 32'd0);
        chk("step0_out", 32'(out_port), 32'd8);
        chk("step0_upd", 32'(update), 32'h0);
        rd("step0_done0", 3'd6, 32'h0);
        cyc(0, 1, 3'd1, 32'd4);
        cyc(1, 0, 3'd0, 32'd0);
        chk("step0_above", 32'(out_port), 32'd8);
        rd("step0_done1", 3'd6, 32'h1);
        cyc(0, 1, 3'd6, 32'h1);
        cyc(0, 1, 3'd2, 32'd1);
        cyc(1, 0, 3'd0, 32'd0);
        chk("lowlim_sat", 32'(out_port), 32'd4);
        rd("lowlim_done", 3'd6, 32'h1);

        // Asynchronous reset in the middle of an adv burst
        cyc(0, 1, 3'd3, 32'b101);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        cyc(0, 1, 3'd0, 32'd2);
        adv = 1'b1;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_out", 32'(out_port), 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_upd", 32'(update), 32'h0);
        rd("async_limit", 3'd1, 32'h7FFF);
        rd("async_ctrl", 3'd3, 32'h0);
        rd("async_step", 3'd2, 32'h1);
        adv = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 1, 3'd0, 32'd7);
        chk("post_rst_wr", 32'(out_port), 32'd7);
        chk("post_rst_upd", 32'(update), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
